instruction_fetch: RTL and testbench

Consumer side of the program counter's fetch address stream. Accepts a 32-bit PC per cycle under a valid/ready handshake and issues a read to synchronous instruction memory with fixed one-cycle latency. Captures returned words with their PC in a small FIFO and presents them to decode under a second valid/ready handshake. A flush input discards all in-flight and buffered fetches when the PC is redirected.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/instruction_fetch_if.sv | 22 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode handshake; instr_misaligned exists only with FETCH_MISALIGN_CHECK_EN.
interface instruction_fetch_if;

    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        instr_misaligned;

    modport master (output instr_valid, output instr, output instr_pc,
                    output instr_misaligned, input instr_ready);
    modport slave  (input instr_valid, input instr, input instr_pc,
                    input instr_misaligned, output instr_ready);
`else
    modport master (output instr_valid, output instr, output instr_pc,
                    input instr_ready);
    modport slave  (input instr_valid, input instr, input instr_pc,
                    output instr_ready);
`endif

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; reset clears storage, clear only empties it.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic         i_Clock,
    input  logic         i_Reset_n,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    always_comb begin
        empty  = (count == '0);
        do_pop = pop && !empty;
        head   = mem[rd_ptr];
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: credit-gated PC accept, one-cycle memory read, entry FIFO to decode.
// Optional FETCH_MISALIGN_CHECK_EN substitutes a NOP for misaligned fetches.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic [31:0] i_PC,
    input  logic        i_FetchValid,
    output logic        o_FetchReady,
    output logic        o_MemReadEnable,
    output logic [31:0] o_MemAddr,
    input  logic [31:0] i_MemData,
    input  logic        i_Flush,
    instruction_fetch_if.master dec
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          inflight_mis;
    logic          pop;
    logic          push;
    logic          accept;
    logic          pc_mis;
    logic [CW:0]   credit_used;

    // Credits count buffered plus in-flight entries, so a push never finds the FIFO full.
    always_comb begin
        pop          = !fifo_empty && dec.instr_ready;
        credit_used  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
        o_FetchReady = i_Reset_n && !i_Flush && (credit_used < (CW+1)'(DEPTH));
        accept       = i_FetchValid && o_FetchReady;
`ifdef FETCH_MISALIGN_CHECK_EN
        pc_mis          = (i_PC[1:0] != 2'b00);
        o_MemReadEnable = accept && !pc_mis;
        o_MemAddr       = i_PC;
`else
        pc_mis          = 1'b0;
        o_MemReadEnable = accept;
        o_MemAddr       = {i_PC[31:2], 2'b00};
`endif
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n || i_Flush) begin
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            inflight_mis <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                inflight_pc  <= i_PC;
                inflight_mis <= pc_mis;
            end
        end
    end

    always_comb begin
        push                  = inflight && !i_Flush;
        push_entry.instr      = inflight_mis ? FETCH_NOP : i_MemData;
        push_entry.pc         = inflight_pc;
        push_entry.misaligned = inflight_mis;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_Clock    (i_Clock),
        .i_Reset_n  (i_Reset_n),
        .clear      (i_Flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

    always_comb begin
        dec.instr_valid = !fifo_empty;
        dec.instr       = head.instr;
        dec.instr_pc    = head.pc;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    assign dec.instr_misaligned = head.misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = head.misaligned;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based model checked every cycle plus directed literal checks.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fvalid;
    logic        flush;
    logic [31:0] pc;
    logic        fready;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_fetch_if dif ();

    instruction_fetch #(.DEPTH(DEPTH)) dut (
        .i_Clock         (clk),
        .i_Reset_n       (rst_n),
        .i_PC            (pc),
        .i_FetchValid    (fvalid),
        .o_FetchReady    (fready),
        .o_MemReadEnable (mem_en),
        .o_MemAddr       (mem_addr),
        .i_MemData       (mem_data),
        .i_Flush         (flush),
        .dec             (dif)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Synchronous memory: data for the address strobed last cycle, junk otherwise.
    logic        rd_q = 1'b0;
    logic [31:0] addr_q = '0;
    always @(posedge clk) begin
        rd_q   <= mem_en;
        addr_q <= mem_addr;
    end
    assign mem_data = rd_q ? word_at(addr_q) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t        q[$];
    bit          m_inflight = 1'b0;
    logic [31:0] m_inf_pc = '0;
    int          m_accepts = 0;

    function automatic bit is_mis(input logic [31:0] p);
`ifdef FETCH_MISALIGN_CHECK_EN
        return p[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t make_entry(input logic [31:0] p);
        exp_t e;
        e.pc    = p;
        e.mis   = is_mis(p);
        e.instr = e.mis ? FETCH_NOP : word_at({p[31:2], 2'b00});
        return e;
    endfunction

    // Model: queue of buffered entries plus one fetch waiting on memory.
    always @(negedge clk) begin : cmp
        bit pop_m;
        bit e_ready;
        bit e_acc;
        int used;
        pop_m   = (q.size() > 0) && (dif.instr_ready === 1'b1);
        used    = q.size() + int'(m_inflight) - int'(pop_m);
        e_ready = (rst_n === 1'b1) && (flush === 1'b0) && (used < DEPTH);
        e_acc   = e_ready && (fvalid === 1'b1);
        chk("fetch_ready", {31'b0, fready}, {31'b0, e_ready});
        chk("mem_en", {31'b0, mem_en}, {31'b0, e_acc && !is_mis(pc)});
        if (e_acc && !is_mis(pc))
            chk("mem_addr", mem_addr, {pc[31:2], 2'b00});
        chk("instr_valid", {31'b0, dif.instr_valid}, {31'b0, q.size() > 0});
        chk("count", 32'(dut.fifo_count), 32'(q.size()));
        if (q.size() > 0) begin
            chk("instr_pc", dif.instr_pc, q[0].pc);
            chk("instr", dif.instr, q[0].instr);
`ifdef FETCH_MISALIGN_CHECK_EN
            chk("instr_mis", {31'b0, dif.instr_misaligned}, {31'b0, q[0].mis});
`endif
        end
        if (rst_n !== 1'b1 || flush === 1'b1) begin
            q.delete();
            m_inflight = 1'b0;
        end else begin
            if (pop_m) void'(q.pop_front());
            if (m_inflight) q.push_back(make_entry(m_inf_pc));
            m_inflight = e_acc;
            m_inf_pc   = pc;
            if (e_acc) m_accepts++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0;
        rst_n = 1'b0;
        fvalid = 1'b1;
        pc = 32'h40;
        flush = 1'b0;
        dif.instr_ready = 1'b0;
        step();
        step();
        chk("rst_ready", {31'b0, fready}, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_valid", {31'b0, dif.instr_valid}, 32'h0);
        chk("rst_instr", dif.instr, 32'h0);
        chk("rst_pc", dif.instr_pc, 32'h0);

        // Back-to-back stream 0x0, 0x4, 0x8 with decode always ready.
        rst_n = 1'b1;
        dif.instr_ready = 1'b1;
        pc = 32'h0;
        step();
        pc = 32'h4;
        step();
        pc = 32'h8;
        chk("s1_valid0", {31'b0, dif.instr_valid}, 32'h1);
        chk("s1_pc0", dif.instr_pc, 32'h0);
        chk("s1_instr0", dif.instr, 32'hC0DE_0000);
        step();
        fvalid = 1'b0;
        chk("s1_pc1", dif.instr_pc, 32'h4);
        chk("s1_instr1", dif.instr, 32'hC0DE_0004);
        step();
        chk("s1_pc2", dif.instr_pc, 32'h8);
        chk("s1_instr2", dif.instr, 32'hC0DE_0008);
        step();
        chk("s1_empty", {31'b0, dif.instr_valid}, 32'h0);

        // Decode stall: only DEPTH accepts before ready falls.
        dif.instr_ready = 1'b0;
        fvalid = 1'b1;
        acc0 = m_accepts;
        for (int i = 0; i < 6; i++) begin
            pc = 32'h20 + 32'(4 * i);
            step();
        end
        chk("stall_accepts", 32'(m_accepts - acc0), 32'd2);
        chk("stall_ready", {31'b0, fready}, 32'h0);
        chk("stall_head", dif.instr_pc, 32'h20);
        dif.instr_ready = 1'b1;
        #1;
        chk("resume_ready", {31'b0, fready}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            pc = 32'h60 + 32'(4 * i);
            step();
        end
        fvalid = 1'b0;
        repeat (4) step();

        // Flush with one buffered entry and one in flight; redirect to 0x100.
        dif.instr_ready = 1'b0;
        fvalid = 1'b1;
        pc = 32'h40;
        step();
        pc = 32'h44;
        step();
        flush = 1'b1;
        pc = 32'h100;
        step();
        flush = 1'b0;
        #1;
        chk("flush_valid", {31'b0, dif.instr_valid}, 32'h0);
        chk("flush_ready", {31'b0, fready}, 32'h1);
        step();
        fvalid = 1'b0;
        dif.instr_ready = 1'b1;
        step();
        chk("redir_valid", {31'b0, dif.instr_valid}, 32'h1);
        chk("redir_pc", dif.instr_pc, 32'h100);
        chk("redir_instr", dif.instr, 32'hC0DE_0100);
        step();
        step();

        // Reset mid-stream while an entry is buffered and another in flight.
        dif.instr_ready = 1'b0;
        fvalid = 1'b1;
        pc = 32'h200;
        step();
        pc = 32'h204;
        step();
        pc = 32'h208;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        fvalid = 1'b0;
        dif.instr_ready = 1'b1;
        chk("rst2_valid", {31'b0, dif.instr_valid}, 32'h0);
        chk("rst2_count", 32'(dut.fifo_count), 32'h0);
        chk("rst2_instr", dif.instr, 32'h0);
        repeat (3) step();

`ifdef FETCH_MISALIGN_CHECK_EN
        fvalid = 1'b1;
        pc = 32'h6;
        #1;
        chk("mis_no_read", {31'b0, mem_en}, 32'h0);
        step();
        fvalid = 1'b0;
        step();
        chk("mis_instr", dif.instr, 32'h0000_0013);
        chk("mis_pc", dif.instr_pc, 32'h6);
        chk("mis_flag", {31'b0, dif.instr_misaligned}, 32'h1);
        step();
        step();
`endif

        // Random valid/ready/flush/reset stress against the model.
        pc = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 29) == 0);
            fvalid = ($urandom_range(0, 9) < 7);
            dif.instr_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 15) == 0)
                pc = $urandom;
            else
                pc = pc + 32'd4;
            step();
        end
        rst_n = 1'b1;
        flush = 1'b0;
        fvalid = 1'b0;
        dif.instr_ready = 1'b1;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
